// File: rtl/led_pattern_scheduler.sv
// Playlist scheduler: steps through a table of {pattern, clk_sel, dwell} entries and drives the LED sequencer.
// Latency: start/stop take effect on the next edge; each entry is shown for max(dwell,1)*TICK_DIV cycles.
// Backpressure: table writes are accepted only while idle (wr_ready low during playback, request held off).
module led_pattern_scheduler #(
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 1000000,
    parameter int DWELL_W  = 8,
    localparam int AW      = $clog2(DEPTH),
    localparam int PW      = $clog2(TICK_DIV)
) (
    input  logic               clk_10MHz,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [AW:0]        num_entries,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [AW-1:0]      wr_addr,
    input  logic [4:0]         wr_pattern,
    input  logic [1:0]         wr_clk_sel,
    input  logic [DWELL_W-1:0] wr_dwell,
    output logic [4:0]         pattern_sel,
    output logic [1:0]         clk_selector,
    output logic [AW-1:0]      cur_index,
    output logic               running,
    output logic               step_pulse
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Playlist table, one register set per entry so reset can clear it.
    logic [4:0]         r_tab_pat [DEPTH];
    logic [1:0]         r_tab_cs  [DEPTH];
    logic [DWELL_W-1:0] r_tab_dw  [DEPTH];

    logic [0:0]         r_state;
    logic [AW:0]        r_len;
    logic [AW-1:0]      r_idx;
    logic [4:0]         r_pat;
    logic [1:0]         r_cs;
    logic [DWELL_W-1:0] r_dwell;
    logic [PW-1:0]      r_presc;
    logic               r_step;

    logic               w_wr_fire;
    logic [AW:0]        w_len_in;
    logic               w_start_ok;
    logic               w_tick;
    logic [AW-1:0]      w_next;

    // A dwell of zero is treated as one tick so every entry is visible.
    function automatic logic [DWELL_W-1:0] f_dwell(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

    assign w_wr_fire  = wr_valid && (r_state == S_IDLE);
    assign w_len_in   = (num_entries > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_entries;
    // A start colliding with an accepted write is dropped so the write lands cleanly.
    assign w_start_ok = start && (w_len_in != '0) && !w_wr_fire;
    assign w_tick     = (r_state == S_RUN) && (r_presc == PW'(TICK_DIV - 1));
    // Wrap by comparing against the latched length, not by DEPTH modulo.
    assign w_next     = ({1'b0, r_idx} == (r_len - (AW+1)'(1))) ? '0 : AW'(r_idx + 1'b1);

    assign wr_ready     = (r_state == S_IDLE);
    assign running      = (r_state == S_RUN);
    assign pattern_sel  = r_pat;
    assign clk_selector = r_cs;
    assign cur_index    = r_idx;
    assign step_pulse   = r_step;

    // Table storage: cleared on reset, written only when the handshake completes in IDLE.
    always_ff @(posedge clk_10MHz) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tab_pat[i] <= '0;
                r_tab_cs[i]  <= '0;
                r_tab_dw[i]  <= '0;
            end
        end else if (w_wr_fire) begin
            r_tab_pat[wr_addr] <= wr_pattern;
            r_tab_cs[wr_addr]  <= wr_clk_sel;
            r_tab_dw[wr_addr]  <= wr_dwell;
        end
    end

    // Playback FSM: stop beats start, start beats tick; tick decrements dwell or advances the entry.
    always_ff @(posedge clk_10MHz) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_idx   <= '0;
            r_pat   <= '0;
            r_cs    <= '0;
            r_dwell <= '0;
            r_presc <= '0;
            r_step  <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (stop) begin
                r_state <= S_IDLE;
                r_idx   <= '0;
                r_pat   <= '0;
                r_cs    <= '0;
                r_dwell <= '0;
                r_presc <= '0;
            end else if (w_start_ok) begin
                r_state <= S_RUN;
                r_len   <= w_len_in;
                r_idx   <= '0;
                r_pat   <= r_tab_pat[0];
                r_cs    <= r_tab_cs[0];
                r_dwell <= f_dwell(r_tab_dw[0]);
                r_presc <= '0;
            end else if (r_state == S_RUN) begin
                if (w_tick) begin
                    r_presc <= '0;
                    if (r_dwell > DWELL_W'(1)) begin
                        r_dwell <= r_dwell - DWELL_W'(1);
                    end else begin
                        r_idx   <= w_next;
                        r_pat   <= r_tab_pat[w_next];
                        r_cs    <= r_tab_cs[w_next];
                        r_dwell <= f_dwell(r_tab_dw[w_next]);
                        r_step  <= 1'b1;
                    end
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_scheduler.sv
module tb_led_pattern_scheduler;

    localparam int DEPTH    = 8;
    localparam int TICK_DIV = 4;
    localparam int DWELL_W  = 8;
    localparam int AW       = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [AW:0]        num_entries = '0;
    logic               wr_valid = 1'b0;
    logic               wr_ready;
    logic [AW-1:0]      wr_addr = '0;
    logic [4:0]         wr_pattern = '0;
    logic [1:0]         wr_clk_sel = '0;
    logic [DWELL_W-1:0] wr_dwell = '0;
    logic [4:0]         pattern_sel;
    logic [1:0]         clk_selector;
    logic [AW-1:0]      cur_index;
    logic               running;
    logic               step_pulse;

    int n_chk  = 0;
    int n_pass = 0;

    led_pattern_scheduler #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .DWELL_W(DWELL_W)) dut (
        .clk_10MHz   (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .num_entries (num_entries),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_pattern  (wr_pattern),
        .wr_clk_sel  (wr_clk_sel),
        .wr_dwell    (wr_dwell),
        .pattern_sel (pattern_sel),
        .clk_selector(clk_selector),
        .cur_index   (cur_index),
        .running     (running),
        .step_pulse  (step_pulse)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [4:0] p, input logic [1:0] c,
                      input logic [DWELL_W-1:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_pattern = p; wr_clk_sel = c; wr_dwell = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic do_start(input logic [AW:0] n);
        start = 1'b1; num_entries = n;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        // 1. reset state and basic two-entry playback
        step(); step();
        rst = 1'b0;
        chk("rst_pat", pattern_sel, 0);
        chk("rst_cs", clk_selector, 0);
        chk("rst_idx", cur_index, 0);
        chk("rst_run", running, 0);
        chk("rst_step", step_pulse, 0);
        chk("rst_wrrdy", wr_ready, 1);

        wr(0, 5'd3, 2'd1, 8'd2);
        wr(1, 5'd7, 2'd2, 8'd1);
        do_start(2);
        chk("start_pat", pattern_sel, 3);
        chk("start_cs", clk_selector, 1);
        chk("start_run", running, 1);
        chk("start_step", step_pulse, 0);
        chk("start_wrrdy", wr_ready, 0);
        repeat (7) step();
        chk("hold_e0_pat", pattern_sel, 3);
        step();
        chk("adv1_pat", pattern_sel, 7);
        chk("adv1_cs", clk_selector, 2);
        chk("adv1_idx", cur_index, 1);
        chk("adv1_step", step_pulse, 1);
        step();
        chk("adv1_step_clr", step_pulse, 0);
        repeat (3) step();
        chk("wrap_pat", pattern_sel, 3);
        chk("wrap_idx", cur_index, 0);
        chk("wrap_step", step_pulse, 1);

        // 2. write blocked while running, then stop
        wr_valid = 1'b1; wr_addr = 0; wr_pattern = 5'd31; wr_clk_sel = 2'd3; wr_dwell = 8'd5;
        step();
        chk("run_wrrdy", wr_ready, 0);
        wr_valid = 1'b0;
        do_stop();
        chk("stop_pat", pattern_sel, 0);
        chk("stop_cs", clk_selector, 0);
        chk("stop_idx", cur_index, 0);
        chk("stop_run", running, 0);
        chk("stop_wrrdy", wr_ready, 1);
        do_start(2);
        chk("tab_kept_pat", pattern_sel, 3);
        chk("tab_kept_cs", clk_selector, 1);
        do_stop();

        // 3. zero length ignored; length clamps to DEPTH and wraps 7->0
        do_start(0);
        chk("len0_run", running, 0);
        chk("len0_pat", pattern_sel, 0);
        for (int i = 2; i < 8; i++) wr(AW'(i), 5'(10 + i), 2'd0, 8'd1);
        do_start(9);
        chk("len9_pat", pattern_sel, 3);
        repeat (32) step();
        chk("len9_idx7", cur_index, 7);
        chk("len9_pat7", pattern_sel, 17);
        repeat (4) step();
        chk("len9_wrap_idx", cur_index, 0);
        chk("len9_wrap_pat", pattern_sel, 3);
        chk("len9_wrap_step", step_pulse, 1);

        // 4. stop coinciding with an advancing tick; start coinciding with a write
        repeat (7) step();
        do_stop();
        chk("stoptick_run", running, 0);
        chk("stoptick_step", step_pulse, 0);
        chk("stoptick_pat", pattern_sel, 0);
        chk("stoptick_idx", cur_index, 0);
        wr_valid = 1'b1; wr_addr = 0; wr_pattern = 5'd21; wr_clk_sel = 2'd3; wr_dwell = 8'd0;
        start = 1'b1; num_entries = 1;
        step();
        wr_valid = 1'b0; start = 1'b0;
        chk("startwr_run", running, 0);
        chk("startwr_pat", pattern_sel, 0);

        // 5. dwell 0 shown for one tick; len 1 reloads with a step pulse every period
        do_start(1);
        chk("len1_pat", pattern_sel, 21);
        chk("len1_cs", clk_selector, 3);
        chk("len1_run", running, 1);
        repeat (3) step();
        chk("len1_nostep", step_pulse, 0);
        step();
        chk("len1_step1", step_pulse, 1);
        chk("len1_pat1", pattern_sel, 21);
        chk("len1_idx1", cur_index, 0);
        step();
        chk("len1_step_clr", step_pulse, 0);
        repeat (3) step();
        chk("len1_step2", step_pulse, 1);

        // 6. reset mid-run, then play the cleared table
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_run", running, 0);
        chk("mrst_pat", pattern_sel, 0);
        chk("mrst_idx", cur_index, 0);
        chk("mrst_step", step_pulse, 0);
        chk("mrst_wrrdy", wr_ready, 1);
        do_start(2);
        chk("zero_run", running, 1);
        chk("zero_pat", pattern_sel, 0);
        chk("zero_cs", clk_selector, 0);
        repeat (4) step();
        chk("zero_adv_idx", cur_index, 1);
        chk("zero_adv_step", step_pulse, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
